// File: rtl/exp_mask_sampler.sv
// exp_mask_sampler: repacks 64-bit squeeze words into 20-bit samples and streams 256 mask coefficients.
// Optional output register enabled by EXP_MASK_SAMPLER_OUT_REG_EN.
module exp_mask_sampler #(
    parameter int EXP_SAMPLE_W     = 20,
    parameter int EXP_VLD_SAMPLE_W = 23,
    parameter int DATA_IN_W        = 64,
    parameter int NUM_SAMPLES      = 4,
    parameter int NUM_COEFFS       = 256,
    parameter int BUF_W            = 160
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            zeroize,
    input  logic                                            en,
    input  logic [DATA_IN_W-1:0]                            data_i,
    input  logic                                            data_valid_i,
    output logic                                            data_ready_o,
    output logic [NUM_SAMPLES-1:0][EXP_VLD_SAMPLE_W-1:0]    coeff_o,
    output logic                                            coeff_valid_o,
    input  logic                                            coeff_ready_i,
    output logic                                            done_o
);
    localparam int          BB        = NUM_SAMPLES * EXP_SAMPLE_W;
    localparam logic [7:0]  BEAT_BITS = 8'(BB);
    localparam logic [7:0]  IN_BITS   = 8'(DATA_IN_W);
    localparam logic [7:0]  FILL_MAX  = 8'(BUF_W - DATA_IN_W);
    localparam logic [6:0]  WORDS     = 7'(NUM_COEFFS * EXP_SAMPLE_W / DATA_IN_W);
    localparam logic [5:0]  LAST_BEAT = 6'(NUM_COEFFS / NUM_SAMPLES - 1);
    localparam logic [EXP_VLD_SAMPLE_W:0] HALF = (EXP_VLD_SAMPLE_W + 1)'(1 << (EXP_SAMPLE_W - 1));
    localparam logic [EXP_VLD_SAMPLE_W:0] Q    = (EXP_VLD_SAMPLE_W + 1)'(8380417);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state_q;
    logic [BUF_W-1:0]     buf_q, buf_d, buf_sh;
    logic [7:0]           fill_q, fill_d, pos;
    logic [6:0]           word_cnt_q;
    logic [5:0]           beat_cnt_q;
    logic                 run, accept, drain, beat_acc;
    logic [NUM_SAMPLES-1:0][EXP_VLD_SAMPLE_W-1:0] mapped;

    // 2^19 - a wraps modulo 2^24 when negative; adding q lands it back in [0, q)
    function automatic logic [EXP_VLD_SAMPLE_W-1:0] map_sample(input logic [EXP_SAMPLE_W-1:0] a);
        logic [EXP_VLD_SAMPLE_W:0] r;
        r = HALF - (EXP_VLD_SAMPLE_W + 1)'(a);
        r = ((EXP_VLD_SAMPLE_W + 1)'(a) > HALF) ? r + Q : r;
        return r[EXP_VLD_SAMPLE_W-1:0];
    endfunction

    always_comb begin
        mapped = '0;
        for (int k = 0; k < NUM_SAMPLES; k++)
            mapped[k] = map_sample(buf_q[k*EXP_SAMPLE_W +: EXP_SAMPLE_W]);
    end

    assign run          = state_q == RUN;
    assign done_o       = state_q == DONE;
    assign data_ready_o = run && fill_q <= FILL_MAX && word_cnt_q < WORDS;
    assign accept       = data_valid_i & data_ready_o;
    assign buf_sh       = drain ? buf_q >> BB : buf_q;
    assign pos          = fill_q - (drain ? BEAT_BITS : 8'd0);
    assign buf_d        = buf_sh | (accept ? {{(BUF_W-DATA_IN_W){1'b0}}, data_i} << pos : '0);
    assign fill_d       = fill_q + (accept ? IN_BITS : 8'd0) - (drain ? BEAT_BITS : 8'd0);

`ifdef EXP_MASK_SAMPLER_OUT_REG_EN
    logic [NUM_SAMPLES-1:0][EXP_VLD_SAMPLE_W-1:0] coeff_q;
    logic                                         cv_q;
    assign drain         = run && fill_q >= BEAT_BITS && (!cv_q || coeff_ready_i);
    assign beat_acc      = cv_q & coeff_ready_i;
    assign coeff_o       = coeff_q;
    assign coeff_valid_o = cv_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coeff_q <= '0;
            cv_q    <= 1'b0;
        end else if (zeroize) begin
            coeff_q <= '0;
            cv_q    <= 1'b0;
        end else if (drain) begin
            coeff_q <= mapped;
            cv_q    <= 1'b1;
        end else if (coeff_ready_i) begin
            cv_q    <= 1'b0;
        end
    end
`else
    assign coeff_valid_o = run && fill_q >= BEAT_BITS;
    assign drain         = coeff_valid_o & coeff_ready_i;
    assign beat_acc      = drain;
    assign coeff_o       = coeff_valid_o ? mapped : '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            buf_q      <= '0;
            fill_q     <= '0;
            word_cnt_q <= '0;
            beat_cnt_q <= '0;
        end else if (zeroize) begin
            state_q    <= IDLE;
            buf_q      <= '0;
            fill_q     <= '0;
            word_cnt_q <= '0;
            beat_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (en) begin
                    state_q    <= RUN;
                    buf_q      <= '0;
                    fill_q     <= '0;
                    word_cnt_q <= '0;
                    beat_cnt_q <= '0;
                end
                RUN: begin
                    buf_q      <= buf_d;
                    fill_q     <= fill_d;
                    word_cnt_q <= word_cnt_q + 7'(accept);
                    beat_cnt_q <= beat_cnt_q + 6'(beat_acc);
                    if (beat_acc && beat_cnt_q == LAST_BEAT) state_q <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_exp_mask_sampler.sv
// tb_exp_mask_sampler: scoreboard bench; driver queues expected beats, monitor pops on each handshake.
module tb_exp_mask_sampler;
    typedef logic [3:0][22:0] beat_t;

    logic        clk = 0;
    logic        rst, zeroize, en, data_valid_i, data_ready_o;
    logic [63:0] data_i;
    beat_t       coeff_o;
    logic        coeff_valid_o, coeff_ready_i, done_o;

    exp_mask_sampler dut (
        .clk(clk), .rst(rst), .zeroize(zeroize), .en(en),
        .data_i(data_i), .data_valid_i(data_valid_i), .data_ready_o(data_ready_o),
        .coeff_o(coeff_o), .coeff_valid_o(coeff_valid_o), .coeff_ready_i(coeff_ready_i),
        .done_o(done_o)
    );

    always #5 clk = ~clk;

    int          checks = 0, failures = 0;
    int          beats_seen, done_cnt;
    bit          abort;
    beat_t       exp_q[$];
    logic [63:0] words[80];

    task automatic chk(input string name, input logic [91:0] act, input logic [91:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [22:0] ref_map(input int a);
        int r;
        r = 524288 - a;
        if (r < 0) r += 8380417;
        return 23'(r);
    endfunction

    always @(negedge clk) begin
        if (coeff_valid_o && coeff_ready_i) begin
            beats_seen++;
            if (exp_q.size() == 0) chk("unexpected_beat", 92'(beats_seen), 92'(0));
            else chk($sformatf("beat%0d", beats_seen - 1), coeff_o, exp_q.pop_front());
        end
        if (done_o) done_cnt++;
    end

    task automatic build(input int mode);
        logic [5119:0] stream;
        beat_t b;
        for (int w = 0; w < 80; w++) begin
            words[w] = {$urandom, $urandom};
            stream[w*64 +: 64] = words[w];
        end
        if (mode == 4) begin
            words[0] = {4'hF, 20'h80001, 20'h80000, 20'h00000};
            words[1][15:0] = 16'hFFFF;
            stream[127:0] = {words[1], words[0]};
        end
        for (int n = 0; n < 64; n++) begin
            for (int k = 0; k < 4; k++) b[k] = ref_map(int'(stream[(4*n+k)*20 +: 20]));
            if (mode == 4 && n == 0) b = {23'd7856130, 23'd8380416, 23'd0, 23'd524288};
            exp_q.push_back(b);
        end
    endtask

    task automatic wait_beats(input int n);
        int c = 0;
        while (beats_seen < n && c < 1000) begin
            @(posedge clk); #1; c++;
        end
        if (beats_seen < n) chk("wait_beats_timeout", 92'(beats_seen), 92'(n));
    endtask

    // mode: 0 plain, 1 backpressure, 2 zeroize at beat 30, 3 en during RUN, 4 directed mapping
    task automatic do_req(input int mode);
        int    c;
        int    bad;
        beat_t snap;
        build(mode);
        beats_seen = 0; done_cnt = 0; abort = 0;
        @(posedge clk); #1 en = 1;
        @(posedge clk); #1 en = 0;
        fork
            begin
                int  w = 0, cy = 0;
                bit  hs;
                data_valid_i = 1; data_i = words[0];
                while (w < 80 && !abort && cy < 1000) begin
                    @(negedge clk); hs = data_ready_o;
                    @(posedge clk); #1; cy++;
                    if (hs) begin
                        w++;
                        if (w < 80) data_i = words[w];
                    end
                end
                data_valid_i = 0;
                if (cy >= 1000) chk("feed_timeout", 92'(w), 92'(80));
            end
            begin
                if (mode == 1) begin
                    wait_beats(10);
                    coeff_ready_i = 0;
                    repeat (2) @(posedge clk);
                    @(negedge clk); snap = coeff_o;
                    chk("stall_valid", 92'(coeff_valid_o), 92'(1));
                    bad = 0;
                    repeat (17) begin
                        @(negedge clk);
                        if (coeff_o !== snap) bad++;
                    end
                    chk("stall_coeff_stable", 92'(bad), 92'(0));
                    chk("stall_data_ready_low", 92'(data_ready_o), 92'(0));
                    @(posedge clk); #1 coeff_ready_i = 1;
                end else if (mode == 2) begin
                    wait_beats(30);
                    zeroize = 1; abort = 1;
                    @(posedge clk); #1 zeroize = 0;
                    chk("zeroize_outputs", {coeff_o, coeff_valid_o, data_ready_o, done_o}, 92'(0));
                    exp_q.delete();
                    repeat (5) @(posedge clk);
                    #1 chk("zeroize_no_done", 92'(done_cnt), 92'(0));
                end else if (mode == 3) begin
                    wait_beats(20);
                    en = 1;
                    @(posedge clk); #1 en = 0;
                end
            end
        join
        if (mode != 2) begin
            c = 0; bad = 0;
            while (done_cnt == 0 && c < 400) begin
                @(posedge clk); #2; c++;
                if (data_ready_o) bad++;
            end
            repeat (3) @(posedge clk);
            #2;
            chk($sformatf("m%0d_ready_low_after_80", mode), 92'(bad), 92'(0));
            chk($sformatf("m%0d_beats", mode), 92'(beats_seen), 92'(64));
            chk($sformatf("m%0d_done_once", mode), 92'(done_cnt), 92'(1));
            chk($sformatf("m%0d_queue_empty", mode), 92'(exp_q.size()), 92'(0));
        end
    endtask

    initial begin
        rst = 1; zeroize = 0; en = 0; data_valid_i = 0; data_i = '0; coeff_ready_i = 1;
        beats_seen = 0; done_cnt = 0;
        repeat (3) @(posedge clk);
        #1 chk("reset_outputs", {coeff_o, coeff_valid_o, data_ready_o, done_o}, 92'(0));
        rst = 0;
        do_req(4);
        do_req(0);
        do_req(1);
        do_req(3);
        do_req(2);
        do_req(0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
